fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag generator for the asynchronous FIFO.
- Sits directly upstream of the FIFO memory in the write clock domain.
- Drives the memory's write address and full input.
- Exports a Gray-coded write pointer to the read domain and synchronizes the read domain's Gray pointer back in.
- Produces full, almost_full, a pessimistic fill level and a sticky overflow flag.

---
 rtl/fifo_wptr_full.sv | 99 +++++++++
 tb/tb_fifo_wptr_full.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and level generator for the async FIFO.
// Lives in the wr_clk domain; only Gray-coded pointers cross to or from the read side.
module fifo_wptr_full #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH):0]   rd_ptr_gray,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     wr_accept,
    output logic [$clog2(DEPTH):0]   wr_ptr_gray,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   wr_level,
    output logic                     overflow
);

    localparam int ADDRSIZE = $clog2(DEPTH);
    localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] r_sync;
    logic [ADDRSIZE:0]                  r_wbin;
    logic [ADDRSIZE:0]                  r_wgray;
    logic                               r_full;
    logic                               r_afull;
    logic [ADDRSIZE:0]                  r_level;
    logic                               r_overflow;

    logic [ADDRSIZE:0] w_rq;
    logic [ADDRSIZE:0] w_rbin;
    logic              w_accept;
    logic [ADDRSIZE:0] w_wbin_next;
    logic [ADDRSIZE:0] w_wgray_next;
    logic [ADDRSIZE:0] w_full_pattern;
    logic              w_full_next;
    logic [ADDRSIZE:0] w_level_next;
    logic              w_afull_next;

    // Plain flop chain: no logic between stages so only a clean Gray value crosses.
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rd_ptr_gray};
        end
    end

    assign w_rq = r_sync[SYNC_STAGES-1];

    // Binary bit i of a Gray code is the XOR of all Gray bits at or above i.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_rbin[i] = ^(w_rq >> i);
        end
    end

    // Handshake: wr_en is a request that may be held; wr_accept marks the cycles on
    // which a write really happens (and is the memory write strobe). The producer
    // must treat any wr_en cycle without wr_accept as dropped. Reset blocks accepts.
    assign w_accept = wr_en & ~r_full & ~wr_rst;

    assign w_wbin_next    = r_wbin + {{ADDRSIZE{1'b0}}, w_accept};
    assign w_wgray_next   = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_full_pattern = {~w_rq[ADDRSIZE:ADDRSIZE-1], w_rq[ADDRSIZE-2:0]};
    assign w_full_next    = (w_wgray_next == w_full_pattern);
    assign w_level_next   = w_wbin_next - w_rbin;
    assign w_afull_next   = (w_level_next >= AFULL_LVL);

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            r_wbin     <= '0;
            r_wgray    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wbin     <= w_wbin_next;
            r_wgray    <= w_wgray_next;
            r_full     <= w_full_next;
            r_afull    <= w_afull_next;
            r_level    <= w_level_next;
            r_overflow <= r_overflow | (wr_en & r_full);
        end
    end

    assign wr_addr     = r_wbin[ADDRSIZE-1:0];
    assign wr_accept   = w_accept;
    assign wr_ptr_gray = r_wgray;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wr_level    = r_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed fill/overflow/drain/wrap/reset phases plus random
// traffic, all checked against an occupancy-count model with a delayed read pointer.
module tb_fifo_wptr_full;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int SS    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b0;
  logic          wr_en  = 1'b0;
  logic [AW:0]   rd_ptr_gray = '0;
  logic [AW-1:0] wr_addr;
  logic          wr_accept;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  fifo_wptr_full #(
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFT),
    .SYNC_STAGES(SS)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .wr_en(wr_en),
    .rd_ptr_gray(rd_ptr_gray),
    .wr_addr(wr_addr),
    .wr_accept(wr_accept),
    .wr_ptr_gray(wr_ptr_gray),
    .full(full),
    .almost_full(almost_full),
    .wr_level(wr_level),
    .overflow(overflow)
  );

  // clock / reset block
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: plain counts of writes and of reads seen by the write side
  int m_wcnt;
  int m_rd;
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;
  bit m_acc;
  int m_rd_pipe[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = (AW+1)'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_rd    = 0;
    m_level = 0;
    m_full  = 0;
    m_afull = 0;
    m_ovf   = 0;
    m_acc   = 0;
    m_rd_pipe.delete();
    repeat (SS) m_rd_pipe.push_back(0);
  endtask

  task automatic set_rd(input int r);
    m_rd        = r;
    rd_ptr_gray = to_gray(r);
  endtask

  task automatic check_regs();
    check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wcnt)));
    check("full", 32'(full), 32'(m_full));
    check("almost_full", 32'(almost_full), 32'(m_afull));
    check("wr_level", 32'(wr_level), m_level);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // driver: entered just after a rising edge, leaves 1 ns after the next one
  task automatic tick(input bit en);
    int seen;
    wr_en = en;
    #1;
    m_acc = en && !m_full;
    check("wr_accept", 32'(wr_accept), 32'(m_acc));
    check("wr_addr", 32'(wr_addr), m_wcnt % DEPTH);
    @(posedge wr_clk);
    if (en && m_full) m_ovf = 1;
    if (m_acc) m_wcnt++;
    m_rd_pipe.push_back(m_rd);
    seen    = m_rd_pipe.pop_front();
    m_level = m_wcnt - seen;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= AFT);
    #1;
    check_regs();
  endtask

  // asserts reset between edges, checks the immediate clear, holds for n edges
  task automatic do_reset(input int n_hold);
    #3;
    set_rd(0);
    wr_en  = 1'b1;
    wr_rst = 1'b1;
    #1;
    check("rst_accept", 32'(wr_accept), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_gray", 32'(wr_ptr_gray), 0);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_level", 32'(wr_level), 0);
    check("rst_ovf", 32'(overflow), 0);
    model_reset();
    for (int i = 0; i < n_hold; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      @(posedge wr_clk);
      #1;
      check("rst_hold_accept", 32'(wr_accept), 0);
      check("rst_hold_addr", 32'(wr_addr), 0);
      check("rst_hold_level", 32'(wr_level), 0);
      check("rst_hold_ovf", 32'(overflow), 0);
    end
    wr_rst = 1'b0;
    wr_en  = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    logic [AW:0]   prev_gray;
    int            wraps;
    bit            full_seen;

    model_reset();
    do_reset(4);

    // fill 16 back-to-back with the read pointer parked at 0
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1);
      if (i == AFT - 2) check("fill_afull_below", 32'(almost_full), 0);
      if (i == AFT - 1) check("fill_afull_at", 32'(almost_full), 1);
    end
    check("fill_full", 32'(full), 1);
    check("fill_level", 32'(wr_level), 16);
    check("fill_gray", 32'(wr_ptr_gray), 32'b11000);

    // writes while full are dropped and latch overflow
    repeat (3) tick(1'b1);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_addr", 32'(wr_addr), 0);
    check("ovf_level", 32'(wr_level), 16);
    tick(1'b0);
    check("ovf_sticky", 32'(overflow), 1);

    // read progress reaches the flags on the third edge
    set_rd(4);
    tick(1'b0);
    check("drain_full_e1", 32'(full), 1);
    tick(1'b0);
    check("drain_full_e2", 32'(full), 1);
    check("drain_afull_e2", 32'(almost_full), 1);
    tick(1'b0);
    check("drain_full_e3", 32'(full), 0);
    check("drain_afull_e3", 32'(almost_full), 0);
    check("drain_level_e3", 32'(wr_level), 12);

    // async reset in the middle of a fill
    do_reset(1);
    repeat (7) tick(1'b1);
    check("midfill_level", 32'(wr_level), 7);
    do_reset(0);

    // wrap-around with the reader trailing four entries behind
    wraps     = 0;
    full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      set_rd(m_wcnt >= 4 ? m_wcnt - 4 : 0);
      prev_addr = wr_addr;
      prev_gray = wr_ptr_gray;
      if (i == 0) check("first_addr_after_rst", 32'(prev_addr), 0);
      tick(1'b1);
      if (m_acc) check("gray_onebit", $countones(prev_gray ^ wr_ptr_gray), 1);
      if (prev_addr == AW'(DEPTH - 1) && wr_addr == '0) wraps++;
      if (full) full_seen = 1;
    end
    check("wrap_count", wraps, 2);
    check("wrap_no_full", 32'(full_seen), 0);

    // random traffic with a reader that never overtakes the writer
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      if ($urandom_range(0, 9) < 4 && m_rd < m_wcnt) set_rd(m_rd + 1);
      tick($urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
